// File: rtl/dbg_pkg.sv
// Shared constants and FSM encoding for the UART debug command receiver.
package dbg_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_BP   = 8'h42;
  localparam logic [7:0] CMD_CLR  = 8'h43;
  localparam logic [7:0] CMD_RST  = 8'h58;

  localparam logic [7:0] ACK_NAK_DEF   = 8'h3F;
  localparam logic [7:0] BP_NOTIFY_DEF = 8'h21;

  typedef enum logic [2:0] {
    StIdle,
    StArg1,
    StArg2,
    StExec,
    StTxAck,
    StTxWait
  } dbg_state_e;

  function automatic logic cmd_has_arg(input logic [7:0] c);
    return (c == CMD_STEP) || (c == CMD_BP);
  endfunction

endpackage

// File: rtl/dbg_bp_match.sv
// Breakpoint address compare with one-shot arming: after a hit or a new 'B' the
// breakpoint stays disarmed until the Z80 leaves the breakpoint address.
module dbg_bp_match (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_addr,
  input  logic        z80_mem_rd,
  input  logic [15:0] bp_addr,
  input  logic        bp_en,
  input  logic        active,
  input  logic        disarm,
  output logic        hit
);

  logic armed_q, armed_d;
  logic addr_eq;

  always_comb begin
    addr_eq = (z80_addr == bp_addr);
    hit     = bp_en & armed_q & z80_mem_rd & addr_eq & active;
    armed_d = armed_q;
    if (disarm || hit) begin
      armed_d = 1'b0;
    end else if (!addr_eq) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/dbg_cmd_rx.sv
// Debug link receiver: assembles 1..3 byte host commands, drives Z80 run control
// and answers each command (plus breakpoint hits) with one byte on the UART.
module dbg_cmd_rx
  import dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 5000000,
  parameter int unsigned RST_CYCLES = 16,
  parameter logic [7:0]  ACK_NAK    = ACK_NAK_DEF,
  parameter logic [7:0]  BP_NOTIFY  = BP_NOTIFY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_done,
  input  logic [15:0] z80_addr,
  input  logic        z80_mem_rd,
  input  logic        step_ack,
  output logic        run_en,
  output logic        step_req,
  output logic        z80_rst_req,
  output logic [15:0] bp_addr,
  output logic        bp_en,
  output logic        rx_overrun
);

  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);
  localparam logic [15:0] RstLast = 16'(RST_CYCLES - 1);

  dbg_state_e  state_q, state_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_vld_q, hold_vld_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  arg1_q, arg1_d;
  logic [7:0]  arg2_q, arg2_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic        tx_done_q, tx_done_d;
  logic        run_en_q, run_en_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [15:0] bp_addr_q, bp_addr_d;
  logic        bp_en_q, bp_en_d;
  logic        bp_pending_q, bp_pending_d;
  logic        rst_req_q, rst_req_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;

  logic consume;
  logic tx_done_seen;
  logic bp_disarm;
  logic bp_hit;

  dbg_bp_match u_bp_match (
    .clk        (clk),
    .rst        (rst),
    .z80_addr   (z80_addr),
    .z80_mem_rd (z80_mem_rd),
    .bp_addr    (bp_addr_q),
    .bp_en      (bp_en_q),
    .active     (run_en_q | (step_cnt_q != 8'd0)),
    .disarm     (bp_disarm),
    .hit        (bp_hit)
  );

  always_comb begin
    consume = hold_vld_q && (state_q inside {StIdle, StArg1, StArg2});

    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    overrun_d   = overrun_q;
    if (consume) begin
      hold_vld_d = 1'b0;
    end
    if (rx_done) begin
      if (!hold_vld_q || consume) begin
        hold_vld_d  = 1'b1;
        hold_data_d = rx_data;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // A stale strobe from an earlier transfer is masked in the tx_wr cycle.
    tx_done_seen = tx_done | (tx_done_q & ~tx_wr_q);
    tx_done_d    = tx_done_seen;

    state_d      = state_q;
    cmd_d        = cmd_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    tmo_d        = tmo_q;
    tx_data_d    = tx_data_q;
    tx_wr_d      = 1'b0;
    run_en_d     = run_en_q;
    bp_addr_d    = bp_addr_q;
    bp_en_d      = bp_en_q;
    bp_pending_d = bp_pending_q;
    bp_disarm    = 1'b0;

    rst_req_d = rst_req_q;
    rst_cnt_d = rst_cnt_q;
    if (rst_req_q) begin
      if (rst_cnt_q == 16'd0) begin
        rst_req_d = 1'b0;
      end else begin
        rst_cnt_d = rst_cnt_q - 16'd1;
      end
    end

    step_cnt_d = step_cnt_q;
    if (step_ack && (step_cnt_q != 8'd0)) begin
      step_cnt_d = step_cnt_q - 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        tmo_d = 32'd0;
        if (hold_vld_q) begin
          cmd_d   = hold_data_q;
          state_d = cmd_has_arg(hold_data_q) ? StArg1 : StExec;
        end else if (bp_pending_q) begin
          tx_data_d    = BP_NOTIFY;
          bp_pending_d = 1'b0;
          state_d      = StTxAck;
        end
      end
      StArg1: begin
        if (hold_vld_q) begin
          arg1_d  = hold_data_q;
          tmo_d   = 32'd0;
          state_d = (cmd_q == CMD_BP) ? StArg2 : StExec;
        end else if (tmo_q == TmoLast) begin
          tmo_d   = 32'd0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StArg2: begin
        if (hold_vld_q) begin
          arg2_d  = hold_data_q;
          tmo_d   = 32'd0;
          state_d = StExec;
        end else if (tmo_q == TmoLast) begin
          tmo_d   = 32'd0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StExec: begin
        tx_data_d = cmd_q;
        state_d   = StTxAck;
        case (cmd_q)
          CMD_RUN:  run_en_d = 1'b1;
          CMD_HALT: begin
            run_en_d   = 1'b0;
            step_cnt_d = 8'd0;
          end
          CMD_STEP: step_cnt_d = arg1_q;
          CMD_BP: begin
            bp_addr_d = {arg1_q, arg2_q};
            bp_en_d   = 1'b1;
            bp_disarm = 1'b1;
          end
          CMD_CLR:  bp_en_d = 1'b0;
          CMD_RST: begin
            run_en_d   = 1'b0;
            step_cnt_d = 8'd0;
            rst_req_d  = 1'b1;
            rst_cnt_d  = RstLast;
          end
          default:  tx_data_d = ACK_NAK;
        endcase
      end
      StTxAck: begin
        tx_wr_d = 1'b1;
        state_d = StTxWait;
      end
      StTxWait: begin
        if (tx_done_seen) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A hit overrides any run/step load applied in the same cycle.
    if (bp_hit) begin
      run_en_d     = 1'b0;
      step_cnt_d   = 8'd0;
      bp_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      hold_data_q  <= 8'd0;
      hold_vld_q   <= 1'b0;
      overrun_q    <= 1'b0;
      cmd_q        <= 8'd0;
      arg1_q       <= 8'd0;
      arg2_q       <= 8'd0;
      tmo_q        <= 32'd0;
      tx_data_q    <= 8'd0;
      tx_wr_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      run_en_q     <= 1'b0;
      step_cnt_q   <= 8'd0;
      bp_addr_q    <= 16'd0;
      bp_en_q      <= 1'b0;
      bp_pending_q <= 1'b0;
      rst_req_q    <= 1'b0;
      rst_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_vld_q   <= hold_vld_d;
      overrun_q    <= overrun_d;
      cmd_q        <= cmd_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      tmo_q        <= tmo_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      tx_done_q    <= tx_done_d;
      run_en_q     <= run_en_d;
      step_cnt_q   <= step_cnt_d;
      bp_addr_q    <= bp_addr_d;
      bp_en_q      <= bp_en_d;
      bp_pending_q <= bp_pending_d;
      rst_req_q    <= rst_req_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_wr       = tx_wr_q;
  assign run_en      = run_en_q;
  assign step_req    = (step_cnt_q != 8'd0);
  assign z80_rst_req = rst_req_q;
  assign bp_addr     = bp_addr_q;
  assign bp_en       = bp_en_q;
  assign rx_overrun  = overrun_q;

endmodule

// File: tb/tb_dbg_cmd_rx.sv
// Bench for dbg_cmd_rx: command table plus hand sequences, replies checked
// against a scoreboard of expected transmit bytes.
module tb_dbg_cmd_rx;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_done = 1'b0;
  logic [15:0] z80_addr = 16'd0;
  logic        z80_mem_rd = 1'b0;
  logic        step_ack = 1'b0;
  logic        run_en;
  logic        step_req;
  logic        z80_rst_req;
  logic [15:0] bp_addr;
  logic        bp_en;
  logic        rx_overrun;

  dbg_cmd_rx #(
    .TIMEOUT    (TMO),
    .RST_CYCLES (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done),
    .z80_addr    (z80_addr),
    .z80_mem_rd  (z80_mem_rd),
    .step_ack    (step_ack),
    .run_en      (run_en),
    .step_req    (step_req),
    .z80_rst_req (z80_rst_req),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  int tx_cnt = 0;
  bit resp_busy = 1'b0;
  int resp_timer = 0;
  int resp_delay = 3;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] ack;
    logic       run;
    logic       step;
    logic       bpen;
    logic [15:0] bpa;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit side: pop expected byte on each tx_wr, answer with tx_done later.
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (resp_busy) begin
        if (resp_timer == 0) begin
          tx_done   = 1'b1;
          resp_busy = 1'b0;
        end else begin
          resp_timer--;
        end
      end
      if (tx_wr === 1'b1) begin
        tx_cnt++;
        if (sb.size() == 0) begin
          check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
        end
        resp_busy  = 1'b1;
        resp_timer = resp_delay;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || resp_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    int model_step;
    int tx_before;

    vecs[0] = '{1, 8'h52, 8'h00, 8'h00, 8'h52, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1, 8'h48, 8'h00, 8'h00, 8'h48, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{2, 8'h53, 8'h05, 8'h00, 8'h53, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{1, 8'h48, 8'h00, 8'h00, 8'h48, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{3, 8'h42, 8'hAB, 8'hCD, 8'h42, 1'b0, 1'b0, 1'b1, 16'hABCD};
    vecs[5] = '{1, 8'h43, 8'h00, 8'h00, 8'h43, 1'b0, 1'b0, 1'b0, 16'hABCD};
    vecs[6] = '{1, 8'h7A, 8'h00, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b0, 16'hABCD};
    vecs[7] = '{2, 8'h53, 8'h00, 8'h00, 8'h53, 1'b0, 1'b0, 1'b0, 16'hABCD};
    vecs[8] = '{1, 8'h00, 8'h00, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b0, 16'hABCD};

    repeat (3) @(negedge clk);
    check("rst_run_en", run_en, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_step_req", step_req, 0);
    check("rst_z80_rst", z80_rst_req, 0);
    check("rst_bp", {bp_en, bp_addr}, 0);
    check("rst_overrun", rx_overrun, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency: effect two edges after the rx_done edge, tx_wr three.
    sb.push_back(8'h52);
    send_byte(8'h52);
    @(negedge clk);
    check("lat_run_early", run_en, 0);
    @(negedge clk);
    check("lat_run", run_en, 1);
    check("lat_txwr_early", tx_wr, 0);
    @(negedge clk);
    check("lat_txwr", tx_wr, 1);
    @(negedge clk);
    check("lat_txwr_once", tx_wr, 0);
    wait_idle();

    for (int i = 0; i < 9; i++) begin
      sb.push_back(vecs[i].ack);
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      wait_idle();
      check($sformatf("vec%0d_run", i), run_en, vecs[i].run);
      check($sformatf("vec%0d_step", i), step_req, vecs[i].step);
      check($sformatf("vec%0d_bp", i), {bp_en, bp_addr}, {vecs[i].bpen, vecs[i].bpa});
    end

    // Stepping: three acks drain N=3, the fourth saturates.
    sb.push_back(8'h53);
    send_byte(8'h53);
    send_byte(8'h03);
    wait_idle();
    model_step = 3;
    check("step_start", step_req, 1);
    for (int i = 0; i < 4; i++) begin
      pulse_ack();
      if (model_step > 0) model_step--;
      check($sformatf("step_ack%0d", i), step_req, (model_step != 0));
    end
    // Load in the EXEC cycle wins over a simultaneous ack.
    sb.push_back(8'h53);
    send_byte(8'h53);
    send_byte(8'h02);
    @(negedge clk);
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    wait_idle();
    pulse_ack();
    check("step_load_wins", step_req, 1);
    pulse_ack();
    check("step_load_drain", step_req, 0);

    // Breakpoint hit, no re-hit while parked on the address, re-arm after leaving.
    sb.push_back(8'h42);
    send_byte(8'h42);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_idle();
    sb.push_back(8'h52);
    send_byte(8'h52);
    wait_idle();
    check("bp_run", run_en, 1);
    sb.push_back(8'h21);
    @(negedge clk);
    z80_addr   = 16'h1234;
    z80_mem_rd = 1'b1;
    @(negedge clk);
    check("bp_hit_stop", run_en, 0);
    wait_idle();
    sb.push_back(8'h52);
    send_byte(8'h52);
    wait_idle();
    check("bp_no_rehit", run_en, 1);
    z80_addr = 16'h1000;
    repeat (2) @(negedge clk);
    sb.push_back(8'h21);
    z80_addr = 16'h1234;
    @(negedge clk);
    check("bp_rehit", run_en, 0);
    wait_idle();
    z80_mem_rd = 1'b0;

    // Argument arriving before the timeout is still accepted.
    sb.push_back(8'h53);
    send_byte(8'h53);
    repeat (TMO - 10) @(negedge clk);
    send_byte(8'h01);
    wait_idle();
    check("tmo_in_time", step_req, 1);
    pulse_ack();
    // Partial command dropped after the timeout, no reply.
    tx_before = tx_cnt;
    send_byte(8'h53);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_no_tx", tx_cnt, tx_before);
    sb.push_back(8'h3F);
    send_byte(8'h7A);
    wait_idle();
    check("tmo_nak_step", step_req, 0);

    // Bytes during TX_WAIT: first held, second dropped.
    resp_delay = 20;
    sb.push_back(8'h43);
    sb.push_back(8'h52);
    send_byte(8'h43);
    repeat (3) @(negedge clk);
    send_byte(8'h52);
    send_byte(8'h48);
    @(negedge clk);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_held", run_en, 0);
    wait_idle();
    resp_delay = 3;
    check("ovr_processed", run_en, 1);
    check("ovr_sticky", rx_overrun, 1);

    // Z80 reset pulse length.
    sb.push_back(8'h58);
    send_byte(8'h58);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (z80_rst_req) cnt++;
    end
    check("xrst_len", cnt, 16);
    check("xrst_run", run_en, 0);
    wait_idle();

    // Asynchronous reset in the middle of a reset pulse.
    sb.push_back(8'h52);
    send_byte(8'h52);
    wait_idle();
    sb.push_back(8'h58);
    send_byte(8'h58);
    repeat (6) @(negedge clk);
    check("arst_pre", z80_rst_req, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_rst_req", z80_rst_req, 0);
    check("arst_outs", {run_en, step_req, tx_wr, bp_en, rx_overrun}, 0);
    check("arst_data", {tx_data, bp_addr}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    sb.push_back(8'h52);
    send_byte(8'h52);
    wait_idle();
    check("post_rst_run", run_en, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_rx.md
Name: dbg_cmd_rx

Overview:
- Host-to-target half of the UART debug link. Takes bytes from the UART receiver, assembles 1- to 3-byte commands and drives Z80 run control: run, halt, N-step, breakpoint, and Z80 reset.
- Acknowledges every command with one byte on the UART transmitter. Sends an unsolicited notify byte on a breakpoint hit.
- Sits between the uart instance and the debug clock-stepping logic, in the clk domain.

Parameters:
- TIMEOUT, 5000000, clk cycles allowed between argument bytes before a partial command is dropped.
- RST_CYCLES, 16, z80_rst_req pulse length in clk cycles.
- ACK_NAK, 8'h3F, byte sent for an unknown command.
- BP_NOTIFY, 8'h21, byte sent on a breakpoint hit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle strobe, new byte
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_done  in  1  one-cycle strobe, transmit finished
- z80_addr  in  16  current Z80 address
- z80_mem_rd  in  1  Z80 memory read active
- step_ack  in  1  one-cycle strobe, stepping logic completed one Z80 clock
- run_en  out  1  free-run Z80 clock enable
- step_req  out  1  high while step_cnt != 0
- z80_rst_req  out  1  Z80 reset request
- bp_addr  out  16  breakpoint address
- bp_en  out  1  breakpoint enabled
- rx_overrun  out  1  sticky: byte lost

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; step_cnt 0; bp_armed 1.
- Input buffer: one-deep holding register hold_data/hold_vld.
  - rx_done sets hold_vld. The FSM consumes the byte in one cycle.
  - rx_done while hold_vld=1 and not consumed that cycle: new byte dropped, rx_overrun<=1 (sticky until rst).
- Commands, first byte:
  - 'R' 0x52: run_en<=1.
  - 'H' 0x48: run_en<=0, step_cnt<=0.
  - 'S' 0x53 + N: step_cnt<=N. N=0 is a legal no-op.
  - 'B' 0x42 + hi + lo: bp_addr<={hi,lo}, bp_en<=1, bp_armed<=0.
  - 'C' 0x43: bp_en<=0.
  - 'X' 0x58: run_en<=0, step_cnt<=0, z80_rst_req high for exactly RST_CYCLES cycles.
  - Any other first byte: reply ACK_NAK, no state change.
- FSM states: IDLE, ARG1, ARG2, EXEC, TX_ACK, TX_WAIT.
  - IDLE: on hold_vld, latch cmd. Go to ARG1 for 'S'/'B', else EXEC.
  - ARG1: on hold_vld, latch arg1. Go to ARG2 for 'B', else EXEC.
  - ARG2: on hold_vld, latch arg2, go to EXEC.
  - EXEC: apply command (one cycle). Load tx_data with cmd (echo) or ACK_NAK. Go to TX_ACK.
  - TX_ACK: tx_wr=1 for one cycle, go to TX_WAIT.
  - TX_WAIT: wait for tx_done, then go to IDLE.
  - Latency: last command byte to effect is 2 cycles; to tx_wr is 3 cycles.
- Timeout: a counter resets on each consumed byte. In ARG1/ARG2, reaching TIMEOUT returns to IDLE with no effect and no reply.
- tx_done is latched on its strobe and cleared when tx_wr fires, so a strobe arriving in the same cycle as the TX_WAIT entry is not lost.
- Bytes received during TX_ACK/TX_WAIT stay in the holding register and are consumed in IDLE.
- Stepping:
  - step_req = (step_cnt != 0).
  - step_ack decrements step_cnt, saturating at 0.
  - A command load of step_cnt in the same cycle as step_ack wins over the decrement.
- Breakpoint:
  - hit = bp_en & bp_armed & z80_mem_rd & (z80_addr == bp_addr) & (run_en | step_req).
  - On hit: run_en<=0, step_cnt<=0, bp_armed<=0, bp_pending<=1.
  - bp_armed returns to 1 when z80_addr != bp_addr, so 'R' resumes past the breakpoint.
  - If the FSM is in IDLE with hold_vld=0 and bp_pending=1: send BP_NOTIFY through TX_ACK/TX_WAIT and clear bp_pending. Otherwise the notify waits for IDLE.
- Hit in the same cycle as EXEC of 'R': the hit wins, run_en=0. The 'R' echo is still sent, followed by BP_NOTIFY.
- Asynchronous rst at any point, including mid-command or mid-transmit: immediate return to reset values. A pending tx_done is ignored.

Decomposition:
- Shared package dbg_pkg holds:
  - command byte constants (CMD_RUN, CMD_HALT, CMD_STEP, CMD_BP, CMD_CLR, CMD_RST);
  - the FSM state encoding;
  - the ACK_NAK and BP_NOTIFY defaults.
- One sub-module, dbg_bp_match: the address compare plus bp_armed re-arm logic.

Test Plan:
- Send 0x52 -> run_en=1 two cycles after rx_done; tx_wr pulses once with tx_data=0x52. Then send 0x48 -> run_en=0, echo 0x48.
- Send 0x53,0x03 and pulse step_ack four times -> step_req high for exactly three acks; step_cnt stays 0 after the fourth; echo 0x53.
- Send 0x42,0x12,0x34, then 0x52; drive z80_mem_rd with z80_addr=0x1234 -> run_en drops the next cycle; tx_data=0x21 after the 0x52 echo completes. Change the address, send 0x52 again -> no re-hit until the address returns to 0x1234.
- Send 0x53 and no further byte for TIMEOUT cycles -> FSM returns to IDLE, no tx_wr; then 0x7A -> reply 0x3F.
- Two rx_done strobes while a reply is in TX_WAIT -> first byte held and processed afterwards; second dropped; rx_overrun=1.
- Send 0x58 with run_en=1 -> run_en=0; z80_rst_req high exactly 16 cycles; assert rst mid-pulse -> all outputs 0 at once.
